mac_accumulator: RTL
====================

Name: mac_accumulator

Overview:
- Stage directly downstream of the registered multiplier.
- Consumes a stream of unsigned 2*BW-bit products and sums each group of LEN consecutive accepted products, producing one dot-product result per group.
- The result sits in a one-entry output register with a valid/ready handshake.
- Accumulation of the next group continues while a result is held; only the group-closing term can stall.

Parameters:
- BW, 16, operand width of the upstream multiplier; product width is 2*BW.
- LEN, 8, products per group; legal range >= 1.
- ACC_W, 2*BW+clog2(LEN), accumulator/result width; derived, never overridden. The sum of LEN full-scale products cannot overflow.

Ports:
- CLK  in  1  clock, rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- prod_in  in  2*BW  product from multiplier, unsigned.
- prod_valid  in  1  prod_in is a valid term this cycle.
- prod_ready  out  1  block accepts prod_in this cycle (combinational).
- clear  in  1  synchronous abort of the partially built group.
- acc_out  out  ACC_W  completed group sum.
- acc_valid  out  1  acc_out holds an unconsumed result.
- acc_ready  in  1  downstream takes acc_out this cycle.
- term_cnt  out  CW  terms accepted in the current group, 0..LEN-1; CW = max(1, clog2(LEN)).

Behaviour:
- Reset is RESETn, asynchronous, active-low; clock is CLK.
- Reset values: acc_reg=0, term_cnt=0, acc_out=0, acc_valid=0.
- Accept = prod_valid & prod_ready. Deliver = acc_valid & acc_ready.
- last = (term_cnt == LEN-1). For LEN=1, last is always 1.
- prod_ready = !(last & acc_valid & !acc_ready). A non-closing term is always accepted.
- Accept, not last: acc_reg <= acc_reg + zero-extended prod_in; term_cnt <= term_cnt+1.
- Accept, last:
  - acc_out <= acc_reg + prod_in; acc_valid <= 1.
  - acc_reg <= 0; term_cnt <= 0.
  - Latency: result visible on acc_out/acc_valid the cycle after the closing term is accepted.
- Deliver without a closing accept: acc_valid <= 0. acc_out keeps its value (don't-care to consumer).
- Deliver and closing accept in the same cycle: acc_out takes the new sum, acc_valid stays 1. There is no bubble and no loss.
- clear=1:
  - acc_reg <= 0; term_cnt <= 0.
  - Any term presented that cycle is dropped (clear wins); prod_ready is still driven per the formula, but the accept has no effect.
  - acc_out/acc_valid are unaffected; a pending result is still delivered.
- prod_valid=0: no state change except the output handshake.
- acc_out is never modified while acc_valid=1 and acc_ready=0.
- Arithmetic: unsigned, modulo 2^ACC_W. True overflow is impossible by construction of ACC_W.
- Reset asserted mid-group or with a pending result: all state is discarded immediately (async). The first accept after release starts a fresh group at term 0.
- Upstream contract: the multiplier has no stall. The controller feeding A/B must hold operands (and the product) while prod_ready=0. This block never drops a term unless clear is asserted.

Decomposition:
- Shared header/package: clog2 constant function, ACC_W derivation, CW derivation. The same header is reused by the multiplier wrappers.
- One sub-module: the existing kogge_stone_Nbit_NOCLK instantiated with bw=ACC_W and cin=0, used as the single acc_reg+prod adder. The adder output is shared by both the acc_reg and acc_out update paths.
- Control (counter, handshake, output register) stays in mac_accumulator; no separate FSM module.

Test Plan:
1. BW=16, LEN=4, acc_ready=1; products 1,2,3,4 on consecutive cycles -> acc_valid=1 with acc_out=10 one cycle after the 4th term. term_cnt sequence: 0,1,2,3,0.
2. Full scale: four products of 0xFFFE0001 -> acc_out=0x3FFF80004 (ACC_W=34), no wrap.
3. Backpressure: acc_ready=0, groups {1,1,1,1} and {2,2,2,2} streamed back to back.
   - First result 4 is held.
   - The second group's terms 1-3 are accepted, then prod_ready=0 on its 4th term.
   - Raise acc_ready for one cycle -> 4 is delivered and the 4th term is accepted in the same cycle; next cycle acc_out=8, acc_valid=1.
4. Same-cycle hand-off: acc_valid=1 (value 10), acc_ready=1 while the closing term of the next group (sum 20) arrives -> acc_out goes 10->20, acc_valid stays 1, no idle cycle.
5. Clear mid-group:
   - Accept 5,6, then clear=1 with prod_valid=1 (value 7) -> the 7 is dropped and term_cnt=0.
   - Then feed 1,1,1,1 -> acc_out=4.
   - A pending result present during the clear is delivered unchanged.
6. Reset mid-operation: pull RESETn low after 2 terms with acc_valid=1 -> acc_out=0, acc_valid=0, term_cnt=0 immediately. Then feed 3,3,3,3 -> acc_out=12. Also run LEN=1: each product appears on acc_out one cycle later.

Source files
------------

// File: rtl/mac_accumulator_pkg.sv
`default_nettype none
// =============================================================================
// mac_accumulator_pkg : shared width helpers for the multiplier/accumulator path
// Revision: 1.0
// =============================================================================
package mac_accumulator_pkg;

   localparam int c_default_bw  = 16;
   localparam int c_default_len = 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = 1; v < n; v = v << 1) r++;
      return r;
   endfunction

   // Wide enough that LEN full-scale products never wrap.
   function automatic int acc_width(input int bw, input int len);
      return 2 * bw + clog2(len);
   endfunction

   function automatic int cnt_width(input int len);
      return (clog2(len) < 1) ? 1 : clog2(len);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mac_accumulator_if.sv
`default_nettype none
// =============================================================================
// mac_accumulator_if : product stream in, group-sum stream out
// Revision: 1.0
// =============================================================================
interface mac_accumulator_if
   import mac_accumulator_pkg::*;
#(
   parameter int BW  = c_default_bw,
   parameter int LEN = c_default_len
) ();

   localparam int c_acc_w = acc_width(BW, LEN);
   localparam int c_cw    = cnt_width(LEN);

   logic [2*BW-1:0]    prod_in;
   logic               prod_valid;
   logic               prod_ready;
   logic               clear;
   logic [c_acc_w-1:0] acc_out;
   logic               acc_valid;
   logic               acc_ready;
   logic [c_cw-1:0]    term_cnt;

   modport master (
      output prod_in, prod_valid, clear, acc_ready,
      input  prod_ready, acc_out, acc_valid, term_cnt
   );

   modport slave (
      input  prod_in, prod_valid, clear, acc_ready,
      output prod_ready, acc_out, acc_valid, term_cnt
   );

endinterface
`default_nettype wire

// File: rtl/mac_accumulator_adder.sv
`default_nettype none
// =============================================================================
// kogge_stone_Nbit_NOCLK : combinational parallel-prefix adder, bw bits + cin
// Revision: 1.0
// =============================================================================
module kogge_stone_Nbit_NOCLK
   import mac_accumulator_pkg::*;
#(
   parameter int bw = 32
) (
   input  wire logic [bw-1:0] a,
   input  wire logic [bw-1:0] b,
   input  wire logic          cin,
   output logic      [bw-1:0] sum,
   output logic               cout
);

   localparam int c_stages = clog2(bw);

   logic [c_stages:0][bw-1:0] w_g;
   logic [c_stages:0][bw-1:0] w_p;
   logic [bw:0]               w_c;

   always_comb begin
      w_g    = '0;
      w_p    = '0;
      w_g[0] = a & b;
      w_p[0] = a ^ b;
      for (int s = 0; s < c_stages; s++) begin
         for (int i = 0; i < bw; i++) begin
            if (i >= (1 << s)) begin
               w_g[s+1][i] = w_g[s][i] | (w_p[s][i] & w_g[s][i-(1<<s)]);
               w_p[s+1][i] = w_p[s][i] & w_p[s][i-(1<<s)];
            end else begin
               w_g[s+1][i] = w_g[s][i];
               w_p[s+1][i] = w_p[s][i];
            end
         end
      end
      // Carry into bit i+1 is the group generate of [i:0], with cin fed through the group propagate.
      w_c[0] = cin;
      for (int i = 0; i < bw; i++) begin
         w_c[i+1] = w_g[c_stages][i] | (w_p[c_stages][i] & cin);
      end
   end

   assign sum  = w_p[0] ^ w_c[bw-1:0];
   assign cout = w_c[bw];

endmodule
`default_nettype wire

// File: rtl/mac_accumulator.sv
`default_nettype none
// =============================================================================
// mac_accumulator : sums groups of LEN products into a one-entry output register
// Revision: 1.0
// =============================================================================
module mac_accumulator
   import mac_accumulator_pkg::*;
#(
   parameter int BW  = c_default_bw,
   parameter int LEN = c_default_len
) (
   input  wire logic          CLK,
   input  wire logic          RESETn,
   mac_accumulator_if.slave   bus
);

   localparam int ACC_W = acc_width(BW, LEN);
   localparam int CW    = cnt_width(LEN);
   localparam logic [CW-1:0] c_last_cnt = CW'(LEN - 1);

   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] r_out;
   logic             r_valid;
   logic [CW-1:0]    r_cnt;

   logic [ACC_W-1:0] w_sum;
   logic             w_unused_cout;
   logic             w_last;
   logic             w_ready;
   logic             w_accept;

   // One adder feeds both the running sum and the output register.
   kogge_stone_Nbit_NOCLK #(
      .bw   (ACC_W)
   ) u_adder (
      .a    (r_acc),
      .b    (ACC_W'(bus.prod_in)),
      .cin  (1'b0),
      .sum  (w_sum),
      .cout (w_unused_cout)
   );

   assign w_last   = (LEN == 1) ? 1'b1 : (r_cnt == c_last_cnt);
   assign w_ready  = !(w_last && r_valid && !bus.acc_ready);
   assign w_accept = bus.prod_valid && w_ready && !bus.clear;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         r_acc   <= '0;
         r_cnt   <= '0;
         r_out   <= '0;
         r_valid <= 1'b0;
      end else begin
         if (bus.clear) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else if (w_accept) begin
            if (w_last) begin
               r_acc <= '0;
               r_cnt <= '0;
               r_out <= w_sum;
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + CW'(1);
            end
         end

         // A closing term overrides a same-cycle delivery so there is no bubble.
         if (w_accept && w_last) begin
            r_valid <= 1'b1;
         end else if (bus.acc_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.prod_ready = w_ready;
   assign bus.acc_out    = r_out;
   assign bus.acc_valid  = r_valid;
   assign bus.term_cnt   = r_cnt;

endmodule
`default_nettype wire
